seq_append: RTL and testbench

Parametrised successor to the frame pre-processor on the Aurora transmit path. It forwards AXI-Stream frames from the local source and appends one trailer beat carrying a wrapping sequence number. The block honours downstream backpressure through a registered output stage. Per-frame append can be disabled, and the block exports frame and sequence status for the AXI-Lite register bank.

---
 rtl/seq_append.sv | 80 ++++++++
 tb/tb_seq_append.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_append.sv
// seq_append: forwards AXI-Stream frames and appends a wrapping sequence-number trailer beat.
module seq_append #(
   parameter int DATA_WIDTH = 32,
   parameter int SEQ_WIDTH  = 16,
   parameter int SEQ_INIT   = 1,
   parameter int CNTR_WIDTH = 64
) (
   input  logic                  m_axis_aclk,
   input  logic                  m_axis_areset,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   input  logic                  ctrl_seq_en,
   input  logic                  ctrl_rst_seq,
   input  logic                  ctrl_rst_cntr,
   output logic [CNTR_WIDTH-1:0] slv_cntr_out,
   output logic [SEQ_WIDTH-1:0]  slv_seq_out
);
   typedef enum logic {S_PASS, S_SEQ} state_t;
   localparam logic [SEQ_WIDTH-1:0] SEQ_RST = SEQ_WIDTH'(SEQ_INIT);
   state_t state, state_nxt;
   logic m_valid, m_last, in_frame, frame_seq_en;
   logic can_load, acc, seq_en_now, load_trailer;
   logic [DATA_WIDTH-1:0] m_data;
   logic [SEQ_WIDTH-1:0] seq_ctr;
   logic [CNTR_WIDTH-1:0] cntr;
   always_ff @(posedge m_axis_aclk)
      state <= m_axis_areset ? S_PASS : state_nxt;
   always_comb
      state_nxt = (state == S_PASS) ? ((acc & s_axis_tlast & seq_en_now) ? S_SEQ : S_PASS)
                                    : (can_load ? S_PASS : S_SEQ);
   always_comb begin
      can_load      = !m_valid | m_axis_tready;
      s_axis_tready = !m_axis_areset & (state == S_PASS) & can_load;
      acc           = s_axis_tvalid & s_axis_tready;
      seq_en_now    = in_frame ? frame_seq_en : ctrl_seq_en;
      load_trailer  = (state == S_SEQ) & can_load;
   end
   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         m_valid      <= 1'b0;
         m_data       <= '0;
         m_last       <= 1'b0;
         in_frame     <= 1'b0;
         frame_seq_en <= 1'b0;
         seq_ctr      <= SEQ_RST;
         cntr         <= '0;
      end else begin
         if (acc) begin
            m_valid      <= 1'b1;
            m_data       <= s_axis_tdata;
            m_last       <= s_axis_tlast & !seq_en_now;
            in_frame     <= !s_axis_tlast;
            frame_seq_en <= seq_en_now;
         end else if (load_trailer) begin
            m_valid <= 1'b1;
            m_data  <= DATA_WIDTH'(seq_ctr);
            m_last  <= 1'b1;
         end else if (m_axis_tready) begin
            m_valid <= 1'b0;
         end
         // the wrap skips values below SEQ_INIT, so a trailer never carries 0 when SEQ_INIT = 1
         if (load_trailer)
            seq_ctr <= (seq_ctr == '1) ? SEQ_RST : seq_ctr + SEQ_WIDTH'(1);
         else if (state == S_PASS && !in_frame && ctrl_rst_seq)
            seq_ctr <= SEQ_RST;
         cntr <= ctrl_rst_cntr ? '0 : cntr + CNTR_WIDTH'(acc & s_axis_tlast);
      end
   end
   assign m_axis_tvalid = m_valid;
   assign m_axis_tdata  = m_data;
   assign m_axis_tlast  = m_last;
   assign slv_cntr_out  = cntr;
   assign slv_seq_out   = seq_ctr;
endmodule

// File: tb/tb_seq_append.sv
// tb_seq_append: random and directed frames against a queue-based model, for 16-bit and 4-bit sequence builds.
module tb_seq_append;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;
   logic seq_en = 1'b1, rst_seq = 1'b0, rst_cntr = 1'b0;
   logic [31:0] s_tdata = '0, last_d;
   logic st[2], mv[2], ml[2];
   logic [31:0] md[2];
   logic [63:0] cnt[2];
   logic [15:0] sq0;
   logic [3:0] sq1;
   logic [15:0] seqo[2];
   assign seqo[0] = sq0;
   assign seqo[1] = {12'd0, sq1};
   int ncmp = 0, nfail = 0, rdy_pct = 100;
   int qsz[2];
   bit pend_m[2];
   logic [32:0] log0[$], log1[$];
   logic [31:0] tl[$];
   seq_append #(.SEQ_WIDTH(16)) u_main (
      .m_axis_aclk(clk), .m_axis_areset(rst),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(st[0]), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(mv[0]), .m_axis_tready(m_tready), .m_axis_tdata(md[0]), .m_axis_tlast(ml[0]),
      .ctrl_seq_en(seq_en), .ctrl_rst_seq(rst_seq), .ctrl_rst_cntr(rst_cntr),
      .slv_cntr_out(cnt[0]), .slv_seq_out(sq0));
   seq_append #(.SEQ_WIDTH(4)) u_small (
      .m_axis_aclk(clk), .m_axis_areset(rst),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(st[1]), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(mv[1]), .m_axis_tready(m_tready), .m_axis_tdata(md[1]), .m_axis_tlast(ml[1]),
      .ctrl_seq_en(seq_en), .ctrl_rst_seq(rst_seq), .ctrl_rst_cntr(rst_cntr),
      .slv_cntr_out(cnt[1]), .slv_seq_out(sq1));
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   initial forever begin
      @(negedge clk);
      m_tready = ($urandom_range(0, 99) < rdy_pct);
   end
   // Model: the queue holds exactly the beats loaded into the output register and not yet taken.
   for (genvar g = 0; g < 2; g++) begin : mdl
      localparam int W = g ? 4 : 16;
      logic [32:0] q[$];
      bit inf, fse, pend, stall, can, acc, en;
      int seq;
      logic [63:0] cn;
      logic [31:0] md_p;
      logic ml_p;
      initial begin
         seq = 1; cn = '0; inf = 0; fse = 0; pend = 0; stall = 0;
         forever begin
            @(negedge clk);
            #4;
            if (rst) begin
               chk("tready_in_reset", 64'(st[g]), 64'(0));
               q.delete(); inf = 0; pend = 0; seq = 1; cn = '0; stall = 0;
            end else begin
               if (stall) begin
                  chk("stall_valid", 64'(mv[g]), 64'(1));
                  chk("stall_data", 64'(md[g]), 64'(md_p));
                  chk("stall_last", 64'(ml[g]), 64'(ml_p));
               end
               chk("tvalid", 64'(mv[g]), 64'(q.size() != 0));
               if (mv[g] && q.size() != 0) begin
                  chk("tdata", 64'(md[g]), 64'(q[0][31:0]));
                  chk("tlast", 64'(ml[g]), 64'(q[0][32]));
               end
               chk("cntr", cnt[g], cn);
               chk("seq", 64'(seqo[g]), 64'(seq));
               can = !mv[g] || m_tready;
               chk("s_tready", 64'(st[g]), 64'(!pend && can));
               if (mv[g] && m_tready) begin
                  if (g == 0) log0.push_back({ml[g], md[g]});
                  else log1.push_back({ml[g], md[g]});
                  if (q.size() != 0) void'(q.pop_front());
               end
               acc = s_tvalid && st[g];
               if (pend && can) begin
                  q.push_back({1'b1, 32'(seq)});
                  seq = (seq == (1 << W) - 1) ? 1 : seq + 1;
                  pend = 0;
               end else if (!pend && !inf && rst_seq) seq = 1;
               if (acc) begin
                  en = inf ? fse : seq_en;
                  fse = en;
                  q.push_back({s_tlast && !en, s_tdata});
                  inf = !s_tlast;
                  pend = s_tlast && en;
               end
               cn = rst_cntr ? '0 : cn + 64'(acc && s_tlast);
               stall = mv[g] && !m_tready;
               md_p = md[g];
               ml_p = ml[g];
            end
            qsz[g] = q.size();
            pend_m[g] = pend;
         end
      end
   end
   task automatic send(input logic [31:0] d, input logic l);
      bit a = 0;
      s_tvalid = 1; s_tdata = d; s_tlast = l;
      if (l) last_d = d;
      for (int n = 0; n < 500 && !a; n++) begin
         #1 a = st[0];
         @(negedge clk);
      end
      if (!a) begin
         ncmp++; nfail++;
         $display("FAIL send_timeout: no input handshake in 500 cycles, expected one");
      end
      s_tvalid = 0;
   endtask
   task automatic frame(input int n, input bit en, input int gap);
      for (int b = 0; b < n; b++) begin
         while ($urandom_range(0, 99) < gap) @(negedge clk);
         if (b == 0) seq_en = en;
         send($urandom, b == n - 1);
         if (b == 0) seq_en = ~en;
      end
   endtask
   task automatic drain();
      bit done = 0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         done = qsz[0] == 0 && qsz[1] == 0 && !pend_m[0] && !pend_m[1];
      end
      if (!done) begin
         ncmp++; nfail++;
         $display("FAIL drain_timeout: output still busy after 300 cycles, expected empty");
      end
      repeat (2) @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      log0.delete(); log1.delete();
   endtask
   task automatic collect(input int w);
      tl.delete();
      if (w == 0) begin
         foreach (log0[i]) if (log0[i][32]) tl.push_back(log0[i][31:0]);
      end else begin
         foreach (log1[i]) if (log1[i][32]) tl.push_back(log1[i][31:0]);
      end
   endtask
   initial begin
      logic [31:0] f2;
      int nl;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_tvalid", 64'(mv[i]), 64'(0));
         chk("rst_tdata", 64'(md[i]), 64'(0));
         chk("rst_tlast", 64'(ml[i]), 64'(0));
         chk("rst_tready", 64'(st[i]), 64'(0));
         chk("rst_cntr", cnt[i], 64'(0));
         chk("rst_seq", 64'(seqo[i]), 64'(1));
      end
      do_reset();
      // three 4-beat frames, full throughput
      repeat (3) frame(4, 1, 0);
      drain();
      chk("t1_beats", 64'(log0.size()), 64'(15));
      foreach (log0[i]) chk("t1_last_pos", 64'(log0[i][32]), 64'(i % 5 == 4));
      collect(0);
      for (int k = 0; k < 3; k++) chk("t1_trailer", 64'(tl[k]), 64'(k + 1));
      chk("t1_cntr", cnt[0], 64'(3));
      chk("t1_seq", 64'(seqo[0]), 64'(4));
      // append disabled on the middle frame
      do_reset();
      frame(4, 1, 0);
      frame(4, 0, 0);
      f2 = last_d;
      frame(4, 1, 0);
      drain();
      chk("t2_beats", 64'(log0.size()), 64'(14));
      collect(0);
      chk("t2_lasts", 64'(tl.size()), 64'(3));
      chk("t2_trailer1", 64'(tl[0]), 64'(1));
      chk("t2_frame2_last", 64'(tl[1]), 64'(f2));
      chk("t2_trailer2", 64'(tl[2]), 64'(2));
      chk("t2_cntr", cnt[0], 64'(3));
      // 4-bit sequence wrap
      do_reset();
      repeat (16) frame($urandom_range(1, 3), 1, 20);
      drain();
      collect(1);
      chk("t3_small_count", 64'(tl.size()), 64'(16));
      for (int k = 0; k < 15; k++) chk("t3_small_trailer", 64'(tl[k]), 64'(k + 1));
      chk("t3_small_wrap", 64'(tl[15]), 64'(1));
      collect(0);
      chk("t3_main_trailer16", 64'(tl[15]), 64'(16));
      // sequence reload held across a frame, counter clear on the tlast cycle
      do_reset();
      repeat (2) frame(2, 1, 0);
      seq_en = 1;
      send(32'hA1, 0);
      rst_seq = 1;
      send(32'hA2, 0);
      send(32'hA3, 0);
      rst_cntr = 1;
      send(32'hA4, 1);
      chk("t4_cntr_zero", cnt[0], 64'(0));
      rst_cntr = 0;
      send(32'hB1, 1);
      rst_seq = 0;
      drain();
      collect(0);
      chk("t4_lasts", 64'(tl.size()), 64'(4));
      chk("t4_trailer_mid", 64'(tl[2]), 64'(3));
      chk("t4_trailer_reload", 64'(tl[3]), 64'(1));
      chk("t4_seq", 64'(seqo[0]), 64'(2));
      chk("t4_cntr", cnt[0], 64'(1));
      // reset while the trailer is stuck behind a stalled output
      do_reset();
      frame(2, 1, 0);
      drain();
      rdy_pct = 0;
      repeat (2) @(negedge clk);
      send(32'hC1, 1);
      repeat (3) @(negedge clk);
      chk("t6_stuck_valid", 64'(mv[0]), 64'(1));
      chk("t6_stuck_tready", 64'(st[0]), 64'(0));
      rst = 1;
      @(negedge clk);
      chk("t6_rst_tvalid", 64'(mv[0]), 64'(0));
      chk("t6_rst_tready", 64'(st[0]), 64'(0));
      rst = 0;
      rdy_pct = 100;
      repeat (2) @(negedge clk);
      log0.delete(); log1.delete();
      frame(1, 1, 0);
      drain();
      chk("t6_beats", 64'(log0.size()), 64'(2));
      collect(0);
      chk("t6_trailer", 64'(tl[0]), 64'(1));
      // random backpressure and source gaps
      do_reset();
      rdy_pct = 70;
      repeat (50) frame($urandom_range(1, 6), 1, 30);
      rdy_pct = 100;
      drain();
      collect(0);
      nl = tl.size();
      chk("t5_trailers", 64'(nl), 64'(50));
      chk("t5_seq", 64'(seqo[0]), 64'(51));
      chk("t5_cntr", cnt[0], 64'(50));
      chk("t5_small_seq", 64'(seqo[1]), 64'(6));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at 900000, expected completion");
      $fatal(1);
   end
endmodule
